// File: rtl/lane_interleaver_2to1.sv
// Two-lane to one-stream interleaver. Each lane has a small FIFO, and the FIFOs
// drain in fixed alternating slots (lane 0, lane 1, ...) so a 1:2 demux recovers the lanes.
module lane_interleaver_2to1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ADDR  = 2
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in_0,
    input  logic             valid_in_0,
    output logic             ready_0,
    input  logic [WIDTH-1:0] data_in_1,
    input  logic             valid_in_1,
    output logic             ready_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             lane_out
);

    localparam logic [ADDR:0] FULL_COUNT = (ADDR + 1)'(DEPTH);

    logic [1:0][WIDTH-1:0] lane_data;
    logic [1:0]            lane_valid;
    logic [1:0]            lane_ready;
    logic [1:0]            lane_pop;
    logic [1:0][WIDTH-1:0] lane_head;
    logic                  slot_sel;

    assign lane_data  = {data_in_1, data_in_0};
    assign lane_valid = {valid_in_1, valid_in_0};
    assign ready_0    = lane_ready[0];
    assign ready_1    = lane_ready[1];

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [ADDR-1:0]  wr_ptr;
        logic [ADDR-1:0]  rd_ptr;
        logic [ADDR:0]    count;
        logic             push;

        // Ready looks only at registered occupancy; a pop in the same slot never frees room early.
        assign lane_ready[l] = !reset && (count != FULL_COUNT);
        assign push          = lane_valid[l] && lane_ready[l];
        assign lane_pop[l]   = (slot_sel == 1'(l)) && (count != '0);
        assign lane_head[l]  = mem[rd_ptr];

        // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
        // NOTE: non-blocking assignments make every register update independent of statement order.
        always_ff @(posedge clk_2f) begin
            if (push) begin
                mem[wr_ptr] <= lane_data[l];
            end
        end

        always_ff @(posedge clk_2f) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR'(1);
                end
                if (lane_pop[l]) begin
                    rd_ptr <= rd_ptr + ADDR'(1);
                end
                case ({push, lane_pop[l]})
                    2'b10:   count <= count + (ADDR + 1)'(1);
                    2'b01:   count <= count - (ADDR + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // The slot advances every cycle, sent or not, so lane alignment downstream never slips.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            slot_sel  <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_out  <= 1'b0;
        end else begin
            slot_sel  <= !slot_sel;
            lane_out  <= slot_sel;
            valid_out <= lane_pop[slot_sel];
            if (lane_pop[slot_sel]) begin
                data_out <= lane_head[slot_sel];
            end
        end
    end

endmodule
